// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and the divisor width.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int BAUD_W = 20;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity is the XOR of the active data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [7:0] data, input int data_bits, input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < data_bits) p = p ^ data[i];
      end
      return (mode == PAR_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/PipeReg.sv
// Generic register with asynchronous active-low reset to a parameterised value.
// All architectural state in the UART blocks is held in these.
module PipeReg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= RESET_VAL;
      else      q <= d;
   end

endmodule

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts clocks within one bit and strobes bit_end on the last one.
// A divisor of 0 behaves like 1, giving one clock per bit.
module tx_bit_timer
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              restart,
   input  logic [BAUD_W-1:0] divisor,
   output logic              bit_end
);

   logic [BAUD_W-1:0] cnt_q;
   logic [BAUD_W-1:0] cnt_d;
   logic [BAUD_W-1:0] limit;

   // The counter sits at zero whenever no frame is running so every frame starts aligned.
   always_comb begin
      limit   = (divisor == '0) ? '0 : divisor - BAUD_W'(1);
      bit_end = run & (cnt_q == limit);
      cnt_d   = (restart | ~run | bit_end) ? '0 : cnt_q + BAUD_W'(1);
   end

   PipeReg #(.WIDTH(BAUD_W), .RESET_VAL('0)) u_cnt (
      .clk (clk),
      .rst (rst),
      .d   (cnt_d),
      .q   (cnt_q)
   );

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: valid/ready byte input, start + LSB-first data + optional
// parity + stop bits on tx_out. The line is registered so reset returns it high cleanly.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = PAR_NONE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BAUD_W-1:0] baud,
   input  logic              tx_en,
   input  logic              tx_valid,
   input  logic [7:0]        tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   uart_state_e       state_q;
   uart_state_e       state_d;
   logic [2:0]        state_raw;
   logic [2:0]        bit_idx_q;
   logic [2:0]        bit_idx_d;
   logic [7:0]        data_q;
   logic [7:0]        data_d;
   logic [BAUD_W-1:0] baud_q;
   logic [BAUD_W-1:0] baud_d;
   logic              line_q;
   logic              line_d;
   logic              bit_end;
   logic              last_stop;
   logic              frame_end;
   logic              accept;

   assign state_q = uart_state_e'(state_raw);

   // Handshake and status; ready depends only on registered state, bit_end and tx_en.
   always_comb begin
      last_stop = (state_q == STOP) && (bit_idx_q == 3'(STOP_BITS - 1));
      frame_end = last_stop & bit_end;
      tx_ready  = tx_en & ((state_q == IDLE) | frame_end);
      accept    = tx_valid & tx_ready;
      tx_done   = frame_end;
      tx_busy   = (state_q != IDLE);
      tx_out    = line_q;
   end

   // Next-state: bit_idx doubles as the data index and the stop-bit count.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      baud_d    = baud_q;
      if (accept) begin
         state_d   = START;
         bit_idx_d = 3'd0;
         data_d    = tx_data;
         baud_d    = baud;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            START: begin
               if (bit_end) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                     state_d   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                     bit_idx_d = 3'd0;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (bit_end) begin
                  state_d   = STOP;
                  bit_idx_d = 3'd0;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     state_d   = IDLE;
                     bit_idx_d = 3'd0;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               bit_idx_d = 3'd0;
            end
         endcase
      end
   end

   // Line level is decoded from the next state so tx_out changes exactly at bit boundaries.
   always_comb begin
      case (state_d)
         START:            line_d = 1'b0;
         DATA:             line_d = data_d[bit_idx_d];
         uart_pkg::PARITY: line_d = parity_bit(data_d, DATA_BITS, PARITY);
         default:          line_d = 1'b1;
      endcase
   end

   PipeReg #(.WIDTH(3), .RESET_VAL(3'(IDLE))) u_state (
      .clk (clk),
      .rst (rst),
      .d   (state_d),
      .q   (state_raw)
   );

   PipeReg #(.WIDTH(3), .RESET_VAL(3'd0)) u_bit_idx (
      .clk (clk),
      .rst (rst),
      .d   (bit_idx_d),
      .q   (bit_idx_q)
   );

   PipeReg #(.WIDTH(8), .RESET_VAL(8'd0)) u_data (
      .clk (clk),
      .rst (rst),
      .d   (data_d),
      .q   (data_q)
   );

   PipeReg #(.WIDTH(BAUD_W), .RESET_VAL('0)) u_baud (
      .clk (clk),
      .rst (rst),
      .d   (baud_d),
      .q   (baud_q)
   );

   PipeReg #(.WIDTH(1), .RESET_VAL(1'b1)) u_line (
      .clk (clk),
      .rst (rst),
      .d   (line_d),
      .q   (line_q)
   );

   tx_bit_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (state_q != IDLE),
      .restart (accept),
      .divisor (baud_q),
      .bit_end (bit_end)
   );

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three parameter variants share one stimulus stream and are
// compared every cycle against a frame-level model of the expected line waveform.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [19:0] baud = 20'd4;
   logic        tx_en = 1'b1;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'd0;

   logic line  [3];
   logic ready [3];
   logic busy  [3];
   logic done  [3];

   localparam int DB [3] = '{8, 8, 7};
   localparam int SB [3] = '{1, 2, 1};
   localparam int PM [3] = '{0, 1, 2};

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
      .clk(clk), .rst(rst), .baud(baud), .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(ready[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(1)) dut1 (
      .clk(clk), .rst(rst), .baud(baud), .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(ready[1]), .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

   uart_tx #(.DATA_BITS(7), .STOP_BITS(1), .PARITY(2)) dut2 (
      .clk(clk), .rst(rst), .baud(baud), .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(ready[2]), .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   always #5 clk = ~clk;

   typedef struct packed {
      logic lvl;
      logic last;
   } slot_t;

   slot_t expq [3][$];
   int    nChecks = 0;
   int    nPass = 0;
   int    cycle = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
   endtask

   // Expected waveform for one frame: one entry per clock, final clock flagged.
   function automatic void pushFrame(input int i, input logic [7:0] d, input logic [19:0] b);
      int   n;
      logic p;
      logic bits [$];
      n = (b == 20'd0) ? 1 : int'(b);
      bits.push_back(1'b0);
      p = 1'b0;
      for (int k = 0; k < DB[i]; k++) begin
         bits.push_back(d[k]);
         p = p ^ d[k];
      end
      if (PM[i] != 0) bits.push_back((PM[i] == 2) ? ~p : p);
      for (int s = 0; s < SB[i]; s++) bits.push_back(1'b1);
      foreach (bits[k]) begin
         for (int r = 0; r < n; r++) expq[i].push_back('{lvl: bits[k], last: 1'b0});
      end
      expq[i][expq[i].size() - 1].last = 1'b1;
   endfunction

   // Mid-cycle comparison, then advance the model across the following rising edge.
   always @(negedge clk) begin
      logic expLvl;
      logic expLast;
      logic expRdy;
      cycle++;
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            expq[i].delete();
            expLvl  = 1'b1;
            expLast = 1'b0;
         end else begin
            expLvl  = (expq[i].size() != 0) ? expq[i][0].lvl  : 1'b1;
            expLast = (expq[i].size() != 0) ? expq[i][0].last : 1'b0;
         end
         expRdy = tx_en & ((expq[i].size() == 0) | expLast);
         checkOutput($sformatf("d%0d.tx_out", i),   32'(line[i]),  32'(expLvl));
         checkOutput($sformatf("d%0d.tx_busy", i),  32'(busy[i]),  32'(expq[i].size() != 0));
         checkOutput($sformatf("d%0d.tx_done", i),  32'(done[i]),  32'(expLast));
         checkOutput($sformatf("d%0d.tx_ready", i), 32'(ready[i]), 32'(expRdy));
         if (rst) begin
            if (expq[i].size() != 0) void'(expq[i].pop_front());
            if (tx_valid && expRdy) pushFrame(i, tx_data, baud);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic en, input logic [7:0] d, input logic [19:0] b);
      @(posedge clk);
      #1;
      tx_valid = v;
      tx_en    = en;
      tx_data  = d;
      baud     = b;
   endtask

   task automatic waitAllIdle();
      int k;
      k = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && k < 500) begin
         @(posedge clk);
         k++;
      end
      checkOutput("idle_wait_bound", 32'(k < 500), 32'd1);
   endtask

   // Receiver-style decode of dut0's line, sampling each bit at its midpoint.
   task automatic loopbackByte(input logic [7:0] d, input logic [19:0] b);
      int          k;
      int          n;
      logic [9:0]  frame;
      n = (b == 20'd0) ? 1 : int'(b);
      applyStimulus(1'b1, 1'b1, d, b);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      k = 0;
      for (int bitn = 0; bitn < 10; bitn++) begin
         while (k < bitn * n + (n + 1) / 2) begin
            @(posedge clk);
            k++;
         end
         #2;
         frame[bitn] = line[0];
      end
      checkOutput("loopback_start", 32'(frame[0]), 32'd0);
      checkOutput("loopback_byte",  32'(frame[8:1]), 32'(d));
      checkOutput("loopback_stop",  32'(frame[9]), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      $display("[TB] single frame 0xA5 at baud 4");
      applyStimulus(1'b1, 1'b1, 8'hA5, 20'd4);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd4);
      waitAllIdle();

      $display("[TB] parity frames 0x07 at baud 2");
      applyStimulus(1'b1, 1'b1, 8'h07, 20'd2);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd2);
      waitAllIdle();

      $display("[TB] back-to-back 0x55 then 0xAA");
      applyStimulus(1'b1, 1'b1, 8'h55, 20'd4);
      applyStimulus(1'b1, 1'b1, 8'hAA, 20'd4);
      repeat (45) @(posedge clk);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd4);
      waitAllIdle();

      $display("[TB] baud 0 frame 0x81");
      applyStimulus(1'b1, 1'b1, 8'h81, 20'd0);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd0);
      waitAllIdle();

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 1'b1, 8'h00, 20'd4);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd4);
      repeat (14) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_async_line", 32'(line[0]), 32'd1);
      checkOutput("rst_async_busy", 32'(busy[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'h5A, 20'd3);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd3);
      waitAllIdle();

      $display("[TB] tx_en low in idle and mid-frame");
      applyStimulus(1'b1, 1'b0, 8'hC3, 20'd2);
      repeat (10) @(posedge clk);
      applyStimulus(1'b0, 1'b1, 8'hC3, 20'd2);
      applyStimulus(1'b1, 1'b1, 8'h96, 20'd2);
      applyStimulus(1'b1, 1'b0, 8'h96, 20'd2);
      repeat (40) @(posedge clk);
      applyStimulus(1'b0, 1'b1, 8'h00, 20'd2);
      waitAllIdle();

      $display("[TB] loopback decode 0x3C");
      loopbackByte(8'h3C, 20'd4);
      waitAllIdle();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 1500; n++) begin
         @(posedge clk);
         #1;
         tx_valid = ($urandom % 3) == 0;
         tx_data  = 8'($urandom);
         tx_en    = ($urandom % 20) != 0;
         if (($urandom % 50) == 0) baud = 20'($urandom_range(0, 5));
      end
      applyStimulus(1'b0, 1'b1, 8'h00, baud);
      waitAllIdle();
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer; the upstream partner of the UART receiver. It accepts a byte through a valid/ready handshake and drives the serial line `tx_out` (idle high). Frame format: start bit, LSB-first data, optional parity, then stop bit(s). Bit timing uses the same 20-bit `baud` divisor convention as the receive side, so `tx_out` can be looped straight into `rx_in` for self-test.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); tx_data[DATA_BITS-1:0] is used.
STOP_BITS, 1, number of stop bits (1 or 2).
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
baud  in  20  clocks per bit; 0 is treated as 1
tx_en  in  1  transmitter enable
tx_valid  in  1  byte offered
tx_data  in  8  byte to send
tx_ready  out  1  block can accept a byte this cycle
tx_out  out  1  serial line output, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of the final stop bit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_out=1, tx_busy=0, tx_done=0, all counters 0. tx_ready follows its own rule (1 in IDLE when tx_en=1). A reset mid-frame truncates the frame immediately; the line returns high with no glitch low.
- States: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE, or STOP -> START on back-to-back.
- Accept: `tx_valid & tx_ready` at a rising edge. On that edge:
  - latch tx_data and baud into internal registers;
  - clear the baud and bit counters;
  - enter START.
  - Latency: tx_out goes low in the cycle after acceptance.
- Bit period: each bit holds tx_out for max(baud,1) clocks, counted by a 20-bit counter that wraps at max(baud,1)-1. A change on `baud` mid-frame has no effect.
- DATA: shift the latched byte LSB first; a 3-bit index runs 0..DATA_BITS-1.
- PARITY: even = XOR of the data bits; odd = its inverse.
- STOP: tx_out=1 for STOP_BITS bit periods.
- tx_ready = tx_en & (IDLE | final clock of final stop bit). This allows gapless back-to-back frames. tx_ready never depends combinationally on tx_valid.
- tx_done pulses high in the final clock of the final stop bit, regardless of whether a new byte is accepted in that cycle.
- tx_busy=1 in every state except IDLE.
- tx_en=0:
  - in IDLE: hold IDLE with tx_ready=0;
  - mid-frame: the frame completes normally, then the block stays IDLE.
- tx_valid without tx_ready is ignored (no buffering). tx_data is sampled only at acceptance.
- Frame length in clocks: max(baud,1) * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).

Decomposition:
- Shared package `uart_pkg`:
  - state encoding constants (IDLE/START/DATA/PARITY/STOP);
  - parity mode constants (PAR_NONE/PAR_EVEN/PAR_ODD);
  - BAUD_W=20.
  The receiver reuses the same package.
- State, baud and bit registers use the team's PipeReg with the async active-low reset.
- One sub-module: `tx_bit_timer`. It holds the baud-period counter, takes the latched divisor and a restart input, and outputs a `bit_end` strobe.

Test Plan:
1. baud=4, PARITY=0, accept 0xA5 at cycle 0 → tx_out from cycle 1, each level held 4 clocks: 0,1,0,1,0,0,1,0,1,1. tx_done high at cycle 40; tx_busy low from cycle 41.
2. PARITY=1 (even), baud=2, send 0x07 → parity bit=1. With PARITY=2 (odd) → parity bit=0. Frame is 22 clocks.
3. Back-to-back: baud=4, tx_valid held high with 0x55 then 0xAA → tx_ready high at cycle 40 only. The second start bit begins at cycle 41 with no idle gap; two tx_done pulses, at cycles 40 and 80.
4. baud=0 → one clock per bit: 0x81 gives 0,1,0,0,0,0,0,0,1,1 on consecutive cycles.
5. rst driven low asynchronously mid-DATA of 0x00 → tx_out=1 immediately, tx_busy=0, tx_ready=1 after rst releases. The next byte sends cleanly.
6. tx_en=0 in IDLE with tx_valid=1 → no transfer and tx_ready=0. tx_en dropped mid-frame → the frame finishes, tx_done pulses, then the block stays IDLE. Loopback to uart_rx recovers 0x3C.
